// File: rtl/ula_seq_if.sv
// Operation/result handshake bundle between the EX-stage issue logic and ula_seq.
interface ula_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [1:0]       status;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, zero, status
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, zero, status
  );
endinterface

// File: rtl/ula_seq.sv
// Registered ALU with valid/ready handshake, iterative MULTU/DIVU into HI/LO,
// and saturating per-op / overflow / error monitoring counters.
module ula_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  ula_seq_if.slave         bus,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  input  logic             clr_counters,
  input  logic [3:0]       cnt_sel,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] overflow_count,
  output logic [CNT_W-1:0] error_count
);
  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_MFHI  = 4'b1100;
  localparam logic [3:0] OP_MFLO  = 4'b1101;
  localparam logic [3:0] OP_SRA   = 4'b1110;
  localparam logic [3:0] OP_INV   = 4'b1111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_OVF  = 2'b01;
  localparam logic [1:0] ST_DIV0 = 2'b10;
  localparam logic [1:0] ST_INV  = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [SH_W-1:0]  iter_q, iter_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [1:0]       status_q, status_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] op_cnt_q [16];
  logic [CNT_W-1:0] op_cnt_d [16];
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             in_ready;
  logic             accept;
  logic             inc_ovf;
  logic             inc_err;
  logic [WIDTH-1:0] alu_res;
  logic [1:0]       alu_status;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic             div_fit;

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign busy     = (state_q == S_MUL) || (state_q == S_DIV);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.status    = status_q;
  assign hi             = hi_q;
  assign lo             = lo_q;
  assign op_count       = op_cnt_q[cnt_sel];
  assign overflow_count = ovf_cnt_q;
  assign error_count    = err_cnt_q;

  // Single-cycle ops evaluated straight from the presented operands, used only on accept.
  always_comb begin
    sum        = bus.a + bus.b;
    diff       = bus.a - bus.b;
    shamt      = bus.a[SH_W-1:0];
    alu_res    = '0;
    alu_status = ST_OK;
    case (bus.op)
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_NOR:  alu_res = ~(bus.a | bus.b);
      OP_ADD: begin
        alu_res = sum;
        if ((bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]))
          alu_status = ST_OVF;
      end
      OP_SUB: begin
        alu_res = diff;
        if ((bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]))
          alu_status = ST_OVF;
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_SLL:  alu_res = bus.b << shamt;
      OP_SRL:  alu_res = bus.b >> shamt;
      OP_SRA:  alu_res = $signed(bus.b) >>> shamt;
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      OP_INV:  alu_status = ST_INV;
      default: alu_res = '0;
    endcase
  end

  // One iteration of shift-add multiply and restoring divide on the work registers.
  always_comb begin
    mul_sum = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh  = {work_hi_q, work_lo_q[WIDTH-1]};
    div_fit = rem_sh >= {1'b0, opnd_q};
  end

  // Sequencer: accepts ops, steps MUL/DIV, and commits results on the edge entering DONE.
  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    opnd_d      = opnd_q;
    work_hi_d   = work_hi_q;
    work_lo_d   = work_lo_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    status_d    = status_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    inc_ovf     = 1'b0;
    inc_err     = 1'b0;
    if (out_valid_q && bus.out_ready)
      out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.op == OP_MULTU) begin
            opnd_d    = bus.a;
            work_hi_d = '0;
            work_lo_d = bus.b;
            iter_d    = '0;
            state_d   = S_MUL;
          end else if (bus.op == OP_DIVU) begin
            if (bus.b == '0) begin
              out_valid_d = 1'b1;
              result_d    = '1;
              zero_d      = 1'b0;
              status_d    = ST_DIV0;
              lo_d        = '1;
              hi_d        = bus.a;
              inc_err     = 1'b1;
              state_d     = S_DONE;
            end else begin
              opnd_d    = bus.b;
              work_hi_d = '0;
              work_lo_d = bus.a;
              iter_d    = '0;
              state_d   = S_DIV;
            end
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            status_d    = alu_status;
            inc_ovf     = (alu_status == ST_OVF);
            inc_err     = (alu_status == ST_INV);
          end
        end
      end
      S_MUL, S_DIV: begin
        if (state_q == S_MUL) begin
          work_hi_d = mul_sum[WIDTH:1];
          work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
        end else begin
          work_hi_d = div_fit ? (rem_sh[WIDTH-1:0] - opnd_q) : rem_sh[WIDTH-1:0];
          work_lo_d = {work_lo_q[WIDTH-2:0], div_fit};
        end
        iter_d = iter_q + SH_W'(1);
        if (iter_q == SH_W'(WIDTH - 1)) begin
          out_valid_d = 1'b1;
          result_d    = work_lo_d;
          zero_d      = (work_lo_d == '0);
          status_d    = ST_OK;
          hi_d        = work_hi_d;
          lo_d        = work_lo_d;
          state_d     = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating monitoring counters; a clear wins over any same-cycle increment.
  always_comb begin
    for (int i = 0; i < 16; i++)
      op_cnt_d[i] = op_cnt_q[i];
    ovf_cnt_d = ovf_cnt_q;
    err_cnt_d = err_cnt_q;
    if (clr_counters) begin
      for (int i = 0; i < 16; i++)
        op_cnt_d[i] = '0;
      ovf_cnt_d = '0;
      err_cnt_d = '0;
    end else begin
      if (accept && (op_cnt_q[bus.op] != '1))
        op_cnt_d[bus.op] = op_cnt_q[bus.op] + CNT_W'(1);
      if (inc_ovf && (ovf_cnt_q != '1))
        ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
      if (inc_err && (err_cnt_q != '1))
        err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      iter_q      <= '0;
      opnd_q      <= '0;
      work_hi_q   <= '0;
      work_lo_q   <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      status_q    <= ST_OK;
      hi_q        <= '0;
      lo_q        <= '0;
      for (int i = 0; i < 16; i++)
        op_cnt_q[i] <= '0;
      ovf_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      opnd_q      <= opnd_d;
      work_hi_q   <= work_hi_d;
      work_lo_q   <= work_lo_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      status_q    <= status_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      for (int i = 0; i < 16; i++)
        op_cnt_q[i] <= op_cnt_d[i];
      ovf_cnt_q   <= ovf_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end
endmodule
